// File: rtl/chunked_adder.sv
// Multi-cycle add/subtract: WIDTH-bit operands processed CHUNK bits per cycle, with a registered carry between chunks.
// Latency: NCHUNK cycles from the accept edge to the done pulse. Throughput: one operation per NCHUNK+1 cycles.
// Backpressure: start is accepted only while busy=0. Requests made while busy are dropped, not queued.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   start, a, b, cin, sub
//                        request and operands, sampled on accept (cin is ignored when sub=1)
//   busy, done           operation in progress / one-cycle result-valid pulse
//   sum, carry, overflow registered result; these change only on the completion edge
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int BW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb_eff;
    logic [WIDTH-1:0] acc;
    logic             c;
    logic [IDXW-1:0]  idx;

    logic [BW-1:0]    base;
    logic [CHUNK-1:0] sa;
    logic [CHUNK-1:0] sb;
    logic [CHUNK:0]   csum;
    logic [WIDTH-1:0] acc_next;
    logic             c_msb;

    always_comb begin
        base     = BW'(int'(idx) * CHUNK);
        sa       = opa[base +: CHUNK];
        sb       = opb_eff[base +: CHUNK];
        csum     = {1'b0, sa} + {1'b0, sb} + {{CHUNK{1'b0}}, c};
        acc_next = acc;
        acc_next[base +: CHUNK] = csum[CHUNK-1:0];
        // Carry into the MSB, recovered from the MSB's own sum bit: s = a ^ b ^ cin.
        // This is only meaningful on the last chunk, and it is only consumed there.
        c_msb    = opa[WIDTH-1] ^ opb_eff[WIDTH-1] ^ acc_next[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            opa      <= '0;
            opb_eff  <= '0;
            acc      <= '0;
            c        <= 1'b0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opa     <= a;
                        // Subtraction is computed as a + ~b + 1. The +1 enters through the initial carry.
                        opb_eff <= sub ? ~b : b;
                        c       <= sub ? 1'b1 : cin;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    c   <= csum[CHUNK];
                    idx <= idx + 1'b1;
                    if (idx == LAST) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        sum      <= acc_next;
                        carry    <= csum[CHUNK];
                        overflow <= c_msb ^ csum[CHUNK];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/chunked_adder.md
# chunked_adder

Parametrised multi-cycle adder/subtractor. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock, and a registered carry links the chunks. A start/busy/done handshake wraps the operation. It is the sequential, configurable successor to the team's 4-bit combinational propagate adder. Use it where a full-width carry chain cannot close timing, or where area matters more than latency.

## Interface
- WIDTH, 16: operand and result width; must be a multiple of CHUNK.
- CHUNK, 4: bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH. NCHUNK = WIDTH/CHUNK.
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; accepted only when busy=0.
- a  input  WIDTH  operand A; sampled on accept.
- b  input  WIDTH  operand B; sampled on accept.
- cin  input  1  carry-in; sampled on accept; ignored when sub=1.
- sub  input  1  mode; 0 computes a+b+cin, 1 computes a−b (a + ~b + 1).
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result.
- carry  output  1  carry-out of the MSB; for sub, 1 means no borrow.
- overflow  output  1  two's-complement overflow.

## Operation
- FSM states are IDLE and RUN. Internal registers:
  - opa, opb_eff (b, or ~b when sub=1)
  - acc (WIDTH bits)
  - c (1 bit)
  - idx (counter, ceil(log2(NCHUNK)) bits, minimum 1)
  - c_msb (carry into bit WIDTH−1)
- IDLE with start=1: latch opa=a and opb_eff. Set c = sub ? 1 : cin, idx=0, busy=1, go to RUN.
- RUN, each cycle:
  - chunk slice [idx*CHUNK +: CHUNK] = opa slice + opb_eff slice + c
  - write the CHUNK-bit result into acc, and the chunk carry-out into c
  - on the last chunk, also capture c_msb, the carry into bit WIDTH−1 from the MSB-bit add
  - idx increments
- RUN with idx = NCHUNK−1: after processing, go to IDLE, busy=0, done=1. On the same edge, load sum=acc(final), carry=final c, overflow = c_msb XOR final c.
- sum, carry and overflow change only on the completion edge. They hold their value until the next completion or reset and never show partial results.
- start while busy=1 is ignored: no queueing, operands not resampled.
- start in the done cycle is accepted normally, since busy=0 there (back-to-back operation).
- CHUNK=WIDTH (NCHUNK=1) is a single RUN cycle and behaves as a registered full-width adder.
- Arithmetic is modulo 2^WIDTH. carry is the bit-WIDTH carry. No saturation.

## Timing
- Reset, on the rising edge with rst=1: state=IDLE, busy=0, done=0, sum=0, carry=0, overflow=0, idx=0, internal registers=0. rst takes priority over start.
- Reset mid-operation aborts it. No done pulse is produced, and outputs return to 0.
- Accept edge E0 (start=1, busy=0): busy=1 from E0 until edge E_NCHUNK.
- Completion edge E_NCHUNK: done=1 and results valid for exactly one cycle after it. busy=0 in that cycle.
- Latency: NCHUNK cycles from accept edge to done. Throughput: one operation per NCHUNK+1 cycles when start is held high.
- done is never high for two consecutive cycles. It is never high while busy=1.
- Inputs a, b, cin and sub may change freely after E0 without affecting the operation in flight.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 unless stated.
- Reset: hold rst for 2 cycles, then release. Required: busy=0, done=0, sum=0x0000, carry=0, overflow=0; start asserted in the same cycle as rst is ignored.
- Add with chunk-boundary carry: a=0x00FF, b=0x0001, cin=0, sub=0. Required: done exactly 4 cycles after the accept edge; sum=0x0100, carry=0, overflow=0; sum unchanged during busy.
- Full ripple with cin: a=0xFFFF, b=0x0001, cin=1. Required: sum=0x0001, carry=1, overflow=0. Then a=0x7FFF, b=0x0001, cin=0. Required: sum=0x8000, carry=0, overflow=1.
- Subtract, cin ignored: a=0x0005, b=0x0007, sub=1, cin=1. Required: sum=0xFFFE, carry=0, overflow=0. Then a=0x8000, b=0x0001, sub=1. Required: sum=0x7FFF, carry=1, overflow=1.
- Handshake and abort:
  - start pulsed again 2 cycles after accept with different operands: ignored, the original result is delivered.
  - start held high: next accept occurs in the done cycle, and done pulses every 5 cycles.
  - rst asserted 2 cycles into an operation: no done pulse, outputs return to 0, and the next start completes correctly.
- Parameter corners: CHUNK=16 with a=0xFFFF, b=0xFFFF, cin=1. Required: done 1 cycle after accept, sum=0xFFFF, carry=1. CHUNK=1: a=0xAAAA, b=0x5555, cin=1. Required: done 16 cycles after accept, sum=0x0000, carry=1, overflow=0.
